// File: rtl/mem_responder_if.sv
// Request/response bundle between the control sequencer and the memory responder.
interface mem_responder_if;
    logic        Read;
    logic        Write;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] Mdatain;
    logic        MemReady;
    logic        MemErr;
    logic        Busy;

    modport master (
        output Read, Write, Address, DataIn,
        input  Mdatain, MemReady, MemErr, Busy
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output Mdatain, MemReady, MemErr, Busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word memory with wait states: one-shot request acceptance, single-cycle ready/error pulse.
//  state | meaning
//  IDLE  | waiting for an armed Read/Write request
//  WAIT  | counting down wait states with the request latched
//  DONE  | access performed on entry; MemReady (and MemErr) high
module mem_responder #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic           clk,
    input  logic           clr,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic                armed_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         data_q;
    logic                rd_q;
    logic                err_q;
    logic [31:0]         mdat_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                req_err;
    logic                enter_done;
    logic                acc_idle;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_data;
    logic                acc_rd;
    logic                acc_err;
    logic                mem_we;

    assign accept  = (state_q == IDLE) && armed_q && (bus.Read || bus.Write);
    assign req_err = (bus.Read && bus.Write) || (|bus.Address[31:ADDR_W]);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (WAIT_STATES == 0) ? DONE : WAIT;
            WAIT: if (cnt_q == 4'd0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy     = (state_q != IDLE);
        bus.MemReady = (state_q == DONE);
        bus.MemErr   = (state_q == DONE) && err_q;
        bus.Mdatain  = mdat_q;
    end

    // With zero wait states DONE is entered on the accepting edge, so the
    // access must use the live request rather than the latched copy.
    assign acc_idle   = (state_q == IDLE);
    assign acc_idx    = acc_idle ? bus.Address[ADDR_W-1:0] : idx_q;
    assign acc_data   = acc_idle ? bus.DataIn : data_q;
    assign acc_rd     = acc_idle ? bus.Read : rd_q;
    assign acc_err    = acc_idle ? req_err : err_q;
    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign mem_we     = clr && enter_done && !acc_rd && !acc_err;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q   <= 4'd0;
            armed_q <= 1'b1;
            idx_q   <= '0;
            data_q  <= 32'd0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            mdat_q  <= 32'd0;
        end else begin
            if (accept) begin
                idx_q   <= bus.Address[ADDR_W-1:0];
                data_q  <= bus.DataIn;
                rd_q    <= bus.Read;
                err_q   <= req_err;
                cnt_q   <= 4'(WAIT_STATES);
                armed_q <= 1'b0;
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if ((state_q == IDLE) && !bus.Read && !bus.Write)
                armed_q <= 1'b1;
            if (enter_done) begin
                if (acc_err)     mdat_q <= 32'd0;
                else if (acc_rd) mdat_q <= mem[acc_idx];
            end
        end
    end

    // No reset: contents survive clr.
    always_ff @(posedge clk) begin
        if (mem_we) mem[acc_idx] <= acc_data;
    end
endmodule
